// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU with single-cycle arithmetic/logic ops,
// an iterative shift-add unsigned multiplier and an iterative restoring
// unsigned divider. Results and NZCV flags are registered and held until
// the consumer takes them over the out_valid/out_ready channel.
module alu_multicycle #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] r,
    output logic [N-1:0] r_hi,
    output logic         v,
    output logic         c,
    output logic         n,
    output logic         z
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MULU = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state, next_state;

    // Captured operation and working registers; lo_q/hi_q double as the
    // visible result words r/r_hi once the operation completes.
    logic [2:0]    op_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  lo_q;
    logic [N-1:0]  hi_q;
    logic [CW-1:0] count;
    logic          v_q, c_q, n_q, z_q;
    logic          out_valid_q;

    logic accept;
    logic div_by_zero;
    logic op_multi;
    logic last_iter;

    logic         is_sub;
    logic [N-1:0] b_eff;
    logic [N:0]   sum;
    logic [N-1:0] sc_r;
    logic         sc_v, sc_c;

    logic [N:0]   mul_sum;
    logic [N:0]   div_shift;
    logic [N:0]   div_trial;
    logic [N-1:0] iter_hi, iter_lo;

    // Handshake decode: in_ready only looks at state and out_ready.
    always_comb begin
        in_ready    = (state == IDLE) || ((state == DONE) && out_ready);
        accept      = in_valid && in_ready;
        div_by_zero = (op == OP_DIVU) && (b == '0);
        op_multi    = (op == OP_MULU) || ((op == OP_DIVU) && !div_by_zero);
        last_iter   = (count == LAST_ITER);
    end

    // Next-state logic for the IDLE/BUSY/DONE controller.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = op_multi ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    next_state = op_multi ? BUSY : DONE;
                end else if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Single-cycle result and flags; SUB is a + ~b + 1 so carry means no borrow.
    always_comb begin
        is_sub = (op == OP_SUB);
        b_eff  = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
        sc_r   = '0;
        sc_v   = 1'b0;
        sc_c   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                sc_r = sum[N-1:0];
                sc_c = sum[N];
                sc_v = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_AND:  sc_r = a & b;
            OP_OR:   sc_r = a | b;
            OP_XOR:  sc_r = a ^ b;
            OP_NOR:  sc_r = ~(a | b);
            default: sc_r = '0;
        endcase
    end

    // One multiply or divide step from the working registers.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(N+1){1'b0}});
        div_shift = {hi_q, lo_q[N-1]};
        div_trial = div_shift - {1'b0, b_q};
        iter_hi   = mul_sum[N:1];
        iter_lo   = {mul_sum[0], lo_q[N-1:1]};
        if (op_q == OP_DIVU) begin
            if (!div_trial[N]) begin
                iter_hi = div_trial[N-1:0];
                iter_lo = {lo_q[N-2:0], 1'b1};
            end else begin
                iter_hi = div_shift[N-1:0];
                iter_lo = {lo_q[N-2:0], 1'b0};
            end
        end
    end

    // State register; out_valid is registered alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            state       <= next_state;
            out_valid_q <= (next_state == DONE);
        end
    end

    // Datapath: capture on accept, iterate while BUSY, hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= OP_ADD;
            b_q   <= '0;
            lo_q  <= '0;
            hi_q  <= '0;
            count <= '0;
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            n_q   <= 1'b0;
            z_q   <= 1'b0;
        end else if (accept) begin
            op_q  <= op;
            b_q   <= b;
            count <= '0;
            if (div_by_zero) begin
                lo_q <= '1;
                hi_q <= a;
                v_q  <= 1'b1;
                c_q  <= 1'b0;
                n_q  <= 1'b1;
                z_q  <= 1'b0;
            end else if (op_multi) begin
                lo_q <= a;
                hi_q <= '0;
            end else begin
                lo_q <= sc_r;
                hi_q <= '0;
                v_q  <= sc_v;
                c_q  <= sc_c;
                n_q  <= sc_r[N-1];
                z_q  <= (sc_r == '0);
            end
        end else if (state == BUSY) begin
            lo_q <= iter_lo;
            hi_q <= iter_hi;
            if (last_iter) begin
                count <= '0;
                n_q   <= iter_lo[N-1];
                z_q   <= (iter_lo == '0);
                if (op_q == OP_DIVU) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                end else begin
                    v_q <= (iter_hi != '0);
                    c_q <= (iter_hi != '0);
                end
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign r         = lo_q;
    assign r_hi      = hi_q;
    assign v         = v_q;
    assign c         = c_q;
    assign n         = n_q;
    assign z         = z_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed checks on an 8-bit instance followed by
// random streaming on a 32-bit instance against a reference model.
module tb_alu_multicycle;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MULU = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOR  = 3'b111;

    localparam int NUM_OPS   = 3000;
    localparam int MAX_CYCLES = 60000;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] r_hi;
        logic [3:0]  f;
    } res_t;

    logic clk = 1'b0;
    logic reset;

    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [2:0] s_op;
    logic [7:0] s_a, s_b, s_r, s_r_hi;
    logic       s_v, s_c, s_n, s_z;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [2:0]  w_op;
    logic [31:0] w_a, w_b, w_r, w_r_hi;
    logic        w_v, w_c, w_n, w_z;

    int n_checks = 0;
    int n_fail   = 0;

    res_t        exp_q[$];
    res_t        e;
    int          accepted, produced, cyc;
    logic        hold_prev, saw_valid;
    logic [68:0] prev_vals;

    alu_multicycle #(.N(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op), .a(s_a), .b(s_b),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .r(s_r), .r_hi(s_r_hi),
        .v(s_v), .c(s_c), .n(s_n), .z(s_z)
    );

    alu_multicycle #(.N(32)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op), .a(w_a), .b(w_b),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .r(w_r), .r_hi(w_r_hi),
        .v(w_v), .c(w_c), .n(w_n), .z(w_z)
    );

    always #5 clk = ~clk;

    // Reference behaviour from plain integer arithmetic; flags packed {v,c,n,z}.
    function automatic res_t refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t        res;
        logic [63:0] full;
        longint      sa, sb, sres;
        logic        fv, fc;
        sa   = longint'(int'(a));
        sb   = longint'(int'(b));
        full = '0;
        res  = '0;
        fv   = 1'b0;
        fc   = 1'b0;
        case (op)
            OP_ADD: begin
                full  = {32'd0, a} + {32'd0, b};
                res.r = full[31:0];
                fc    = (full > 64'h0000_0000_FFFF_FFFF);
                sres  = sa + sb;
                fv    = (sres > SMAX) || (sres < SMIN);
            end
            OP_SUB: begin
                res.r = a - b;
                fc    = (a >= b);
                sres  = sa - sb;
                fv    = (sres > SMAX) || (sres < SMIN);
            end
            OP_AND: res.r = a & b;
            OP_OR:  res.r = a | b;
            OP_XOR: res.r = a ^ b;
            OP_NOR: res.r = ~(a | b);
            OP_MULU: begin
                full     = {32'd0, a} * {32'd0, b};
                res.r    = full[31:0];
                res.r_hi = full[63:32];
                fv       = (res.r_hi != 0);
                fc       = fv;
            end
            default: begin
                if (b == 0) begin
                    res.r    = 32'hFFFF_FFFF;
                    res.r_hi = a;
                    fv       = 1'b1;
                end else begin
                    res.r    = a / b;
                    res.r_hi = a % b;
                end
            end
        endcase
        res.f = {fv, fc, res.r[31], (res.r == 0)};
        return res;
    endfunction

    task automatic checkValue(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        s_in_valid = 1'b1;
        s_op       = op;
        s_a        = a;
        s_b        = b;
        #1;
        checkValue("in_ready at issue", s_in_ready, 1'b1);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        s_op       = 3'($urandom);
        s_a        = 8'($urandom);
        s_b        = 8'($urandom);
    endtask

    task automatic waitValid(input int max_cycles, output int lat);
        lat = 1;
        while (!s_out_valid && lat < max_cycles) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic checkOutput(input string tag, input int exp_lat, input logic [7:0] er,
                               input logic [7:0] erhi, input logic [3:0] ef);
        int lat;
        waitValid(20, lat);
        checkValue({tag, " latency"}, lat, exp_lat);
        checkValue({tag, " out_valid"}, s_out_valid, 1'b1);
        checkValue({tag, " r"}, s_r, er);
        checkValue({tag, " r_hi"}, s_r_hi, erhi);
        checkValue({tag, " vcnz"}, {s_v, s_c, s_n, s_z}, ef);
    endtask

    initial begin
        reset       = 1'b1;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        s_op        = OP_ADD;
        s_a         = '0;
        s_b         = '0;
        w_in_valid  = 1'b0;
        w_out_ready = 1'b1;
        w_op        = OP_ADD;
        w_a         = '0;
        w_b         = '0;
        $display("[TB] starting");

        repeat (3) @(posedge clk);
        #1;
        checkValue("reset out_valid", s_out_valid, 1'b0);
        checkValue("reset r", {s_r, s_r_hi}, 16'h0000);
        checkValue("reset vcnz", {s_v, s_c, s_n, s_z}, 4'b0000);
        checkValue("reset in_ready", s_in_ready, 1'b1);
        checkValue("reset w out_valid", w_out_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of a multiply.
        applyStimulus(OP_MULU, 8'hFF, 8'hFF);
        checkValue("busy in_ready", s_in_ready, 1'b0);
        checkValue("busy out_valid", s_out_valid, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        checkValue("mid reset out_valid", s_out_valid, 1'b0);
        checkValue("mid reset r", {s_r, s_r_hi}, 16'h0000);
        checkValue("mid reset vcnz", {s_v, s_c, s_n, s_z}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            saw_valid = saw_valid | s_out_valid;
        end
        checkValue("post reset out_valid never", saw_valid, 1'b0);
        checkValue("post reset in_ready", s_in_ready, 1'b1);
        applyStimulus(OP_ADD, 8'd1, 8'd1);
        checkOutput("add 1+1", 1, 8'd2, 8'd0, 4'b0000);

        // Arithmetic flags, multiply and divide.
        applyStimulus(OP_ADD, 8'h7F, 8'h01);
        checkOutput("add 7f+1", 1, 8'h80, 8'h00, 4'b1010);
        applyStimulus(OP_SUB, 8'h05, 8'h05);
        checkOutput("sub 5-5", 1, 8'h00, 8'h00, 4'b0101);
        applyStimulus(OP_SUB, 8'h00, 8'h01);
        checkOutput("sub 0-1", 1, 8'hFF, 8'h00, 4'b0010);
        applyStimulus(OP_MULU, 8'hFF, 8'hFF);
        checkOutput("mulu ff*ff", 9, 8'h01, 8'hFE, 4'b1100);
        applyStimulus(OP_MULU, 8'd3, 8'd4);
        checkOutput("mulu 3*4", 9, 8'h0C, 8'h00, 4'b0000);
        applyStimulus(OP_DIVU, 8'd200, 8'd7);
        checkOutput("divu 200/7", 9, 8'd28, 8'd4, 4'b0000);
        applyStimulus(OP_DIVU, 8'h55, 8'h00);
        checkOutput("divu 55/0", 1, 8'hFF, 8'h55, 4'b1010);

        // Backpressure on an AND result, then back-to-back logic ops.
        @(posedge clk);
        #1;
        s_out_ready = 1'b0;
        applyStimulus(OP_AND, 8'hF0, 8'h3C);
        checkOutput("and", 1, 8'h30, 8'h00, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_in_valid = 1'b1;
            s_op       = OP_OR;
            s_a        = 8'hF0;
            s_b        = 8'h0C;
            #1;
            checkValue("hold in_ready", s_in_ready, 1'b0);
            checkValue("hold out_valid", s_out_valid, 1'b1);
            checkValue("hold r", {s_r, s_r_hi}, 16'h3000);
            checkValue("hold vcnz", {s_v, s_c, s_n, s_z}, 4'b0000);
        end
        @(negedge clk);
        s_out_ready = 1'b1;
        #1;
        checkValue("or issue in_ready", s_in_ready, 1'b1);
        @(posedge clk);
        #1;
        checkValue("or out_valid", s_out_valid, 1'b1);
        checkValue("or r", {s_r, s_r_hi}, 16'hFC00);
        checkValue("or vcnz", {s_v, s_c, s_n, s_z}, 4'b0010);
        @(negedge clk);
        s_op = OP_XOR;
        s_a  = 8'hF0;
        s_b  = 8'hFF;
        #1;
        checkValue("xor issue in_ready", s_in_ready, 1'b1);
        @(posedge clk);
        #1;
        checkValue("xor r", {s_r, s_r_hi}, 16'h0F00);
        checkValue("xor vcnz", {s_v, s_c, s_n, s_z}, 4'b0000);
        @(negedge clk);
        s_op = OP_NOR;
        s_a  = 8'hF0;
        s_b  = 8'h0F;
        #1;
        checkValue("nor issue in_ready", s_in_ready, 1'b1);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        checkValue("nor r", {s_r, s_r_hi}, 16'h0000);
        checkValue("nor vcnz", {s_v, s_c, s_n, s_z}, 4'b0001);

        // Random streaming on the 32-bit instance.
        $display("[TB] random streaming, %0d ops", NUM_OPS);
        accepted  = 0;
        produced  = 0;
        cyc       = 0;
        hold_prev = 1'b0;
        prev_vals = '0;
        while ((accepted < NUM_OPS || exp_q.size() > 0) && cyc < MAX_CYCLES) begin
            @(negedge clk);
            cyc++;
            if (accepted < NUM_OPS) begin
                w_out_ready = ($urandom_range(3) != 0);
                w_in_valid  = ($urandom_range(3) != 0);
                w_op        = 3'($urandom);
                case ($urandom_range(7))
                    0:       w_a = 32'h7FFF_FFFF;
                    1:       w_a = 32'h8000_0000;
                    2:       w_a = 32'hFFFF_FFFF;
                    3:       w_a = 32'($urandom_range(15));
                    default: w_a = $urandom;
                endcase
                case ($urandom_range(7))
                    0:       w_b = 32'd0;
                    1:       w_b = 32'($urandom_range(15));
                    2:       w_b = 32'hFFFF_FFFF;
                    3:       w_b = 32'h8000_0000;
                    default: w_b = $urandom;
                endcase
            end else begin
                w_in_valid  = 1'b0;
                w_out_ready = 1'b1;
            end
            #1;
            if (hold_prev) begin
                checkValue("stream hold stable", {w_out_valid, w_r, w_r_hi, w_v, w_c, w_n, w_z}, prev_vals);
            end
            if (w_out_valid && w_out_ready) begin
                checkValue("stream result pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    produced++;
                    checkValue("stream r", w_r, e.r);
                    checkValue("stream r_hi", w_r_hi, e.r_hi);
                    checkValue("stream vcnz", {w_v, w_c, w_n, w_z}, e.f);
                end
            end
            hold_prev = w_out_valid && !w_out_ready;
            prev_vals = {w_out_valid, w_r, w_r_hi, w_v, w_c, w_n, w_z};
            if (w_in_valid && w_in_ready) begin
                exp_q.push_back(refModel(w_op, w_a, w_b));
                accepted++;
            end
        end
        w_in_valid = 1'b0;
        checkValue("stream accepted count", accepted, NUM_OPS);
        checkValue("stream queue drained", exp_q.size(), 0);
        checkValue("stream produced count", produced, accepted);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
